// File: rtl/mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_rr_arbiter
// Description : Round-robin arbiter sharing one fixed-latency memory read
//               port among N_REQ requesters, with a tag pipeline for routing.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_rr_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic                        mem_valid,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    input  logic                        mem_ready,
    input  logic [DATA_WIDTH-1:0]       mem_data
);

    localparam int                 c_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(N_REQ - 1);

    logic [c_PTR_W-1:0]    r_rr_ptr;
    logic [c_PTR_W-1:0]    w_win;
    logic [c_PTR_W-1:0]    w_cand;
    logic                  w_any;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_addr_arr [N_REQ];

    logic                  r_tag_vld [MEM_LATENCY];
    logic [c_PTR_W-1:0]    r_tag_idx [MEM_LATENCY];

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_addr
            assign w_addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    // Search from rr_ptr upward, wrapping modulo N_REQ; first valid wins.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = c_PTR_W'((int'(r_rr_ptr) + k) % N_REQ);
            if (!w_any && req_valid[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
    end

    // Reset gates the grant so nothing is accepted while rst is low.
    assign w_accept  = rst & mem_ready & w_any;
    assign mem_valid = |req_valid;
    assign mem_addr  = w_any ? w_addr_arr[w_win] : '0;
    assign rsp_data  = mem_data;

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_onehot
            assign req_ready[i] = w_accept && (w_win == c_PTR_W'(i));
            assign rsp_valid[i] = r_tag_vld[MEM_LATENCY-1] &&
                                  (r_tag_idx[MEM_LATENCY-1] == c_PTR_W'(i));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_win == c_LAST) ? '0 : w_win + 1'b1;
        end
    end

    generate
        for (genvar s = 0; s < MEM_LATENCY; s++) begin : g_tag
            if (s == 0) begin : g_head
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        r_tag_vld[s] <= 1'b0;
                        r_tag_idx[s] <= '0;
                    end else begin
                        r_tag_vld[s] <= w_accept;
                        r_tag_idx[s] <= w_win;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        r_tag_vld[s] <= 1'b0;
                        r_tag_idx[s] <= '0;
                    end else begin
                        r_tag_vld[s] <= r_tag_vld[s-1];
                        r_tag_idx[s] <= r_tag_idx[s-1];
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/mem_rr_arbiter.md
MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of engine requesters sharing one instruction-memory read port (2..16).
REQ-002 Parameter ADDR_WIDTH, default 11, memory address width.
REQ-003 Parameter DATA_WIDTH, default 16, memory word width.
REQ-004 Parameter MEM_LATENCY, default 1, fixed cycles from accepted address to valid read data (1..4).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  N_REQ  per-requester read request.
REQ-008 req_addr  input  N_REQ*ADDR_WIDTH  per-requester address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 req_ready  output  N_REQ  one-hot grant; request i accepted in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-010 rsp_valid  output  N_REQ  one-hot; data on rsp_data belongs to requester i.
REQ-011 rsp_data  output  DATA_WIDTH  read data broadcast to all requesters.
REQ-012 mem_valid  output  1  address valid toward memory.
REQ-013 mem_addr  output  ADDR_WIDTH  address toward memory.
REQ-014 mem_ready  input  1  memory accepts the address this cycle.
REQ-015 mem_data  input  DATA_WIDTH  memory read data, valid exactly MEM_LATENCY cycles after acceptance.

Function
REQ-016 The block SHALL keep a round-robin pointer rr_ptr (clog2(N_REQ) bits) naming the highest-priority requester.
REQ-017 The winner SHALL be the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
REQ-018 mem_valid SHALL equal OR of req_valid; mem_addr SHALL be the winner's address, or 0 when no request is present.
REQ-019 req_ready SHALL be one-hot at the winner only when mem_ready=1; it SHALL be all zeros otherwise.
REQ-020 On an accepted grant to requester w, rr_ptr SHALL become (w+1) modulo N_REQ; w=N_REQ-1 SHALL wrap to 0.
REQ-021 With no grant (no request, or mem_ready=0), rr_ptr SHALL hold.
REQ-022 Grant logic SHALL be combinational from req_valid, rr_ptr and mem_ready; at most one acceptance per cycle.
REQ-023 A tag pipeline of depth MEM_LATENCY SHALL carry {valid, winner index} of each accepted request.
REQ-024 rsp_valid SHALL be the one-hot decode of the pipeline tail, asserted exactly MEM_LATENCY cycles after acceptance, for one cycle.
REQ-025 rsp_data SHALL equal mem_data combinationally and carry no meaning when rsp_valid=0.
REQ-026 Back-to-back acceptances SHALL produce back-to-back responses in acceptance order; throughput is 1 word/cycle.
REQ-027 A requester holding req_valid continuously while alone SHALL be granted every cycle that mem_ready=1.
REQ-028 With all N_REQ requesters continuously valid, each SHALL be granted exactly once in every N_REQ consecutive accepted cycles.
REQ-029 A requester SHALL keep req_valid and req_addr stable until it is accepted; the arbiter does not latch unaccepted addresses.
REQ-030 Deasserting req_valid before acceptance SHALL drop the request silently; rr_ptr SHALL be unaffected.

Reset
REQ-031 When rst=0, rr_ptr SHALL be 0 and all tag pipeline stages SHALL be invalid, asynchronously.
REQ-032 During reset, req_ready and rsp_valid SHALL be 0; mem_valid SHALL follow REQ-018.
REQ-033 Reset asserted while reads are in flight SHALL discard them; after release, no rsp_valid SHALL appear for them.
REQ-034 The first grant after reset release SHALL follow REQ-017 from rr_ptr=0.

Verification
REQ-035 N_REQ=4, MEM_LATENCY=1: req_valid=4'b1111, mem_ready=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp_valid follows one cycle later in the same order.
REQ-036 Only requester 2 valid, addr=0x0A5, MEM_LATENCY=2 -> req_ready=4'b0100 every cycle; rsp_valid=4'b0100 two cycles after each acceptance; rsp_data = mem_data.
REQ-037 rr_ptr=3, req_valid=4'b1001 -> grant 3, then rr_ptr wraps to 0 and 0 is granted next.
REQ-038 mem_ready=0 for 3 cycles with req_valid=4'b0110 -> req_ready=0 throughout, rr_ptr unchanged; on mem_ready=1, requester 1 is granted first.
REQ-039 MEM_LATENCY=3: accept 2 reads, assert rst=0 one cycle later -> no rsp_valid after release; next grant goes to the lowest-index valid requester.
REQ-040 Random req_valid and mem_ready for 10k cycles -> scoreboard: every acceptance gets exactly one response MEM_LATENCY cycles later with the correct index; no requester waits more than N_REQ accepted grants while continuously valid.
